slt_seq: RTL and testbench
==========================

Name: slt_seq

Overview:
- Parametrised, multi-cycle successor to the team's combinational set-less-than unit.
- Computes x - y as x + ~y + 1, DIGIT bits per clock, LSB chunk first, using a registered carry.
- Produces set (signed or unsigned less-than), signed overflow, zero and the full difference.
- Sits beside the ALU datapath as a long-latency compare unit, using a start/ready/done handshake.

Parameters:
- WIDTH, 32: operand width in bits. Must be >= 2.
- DIGIT, 4: bits processed per RUN cycle. Must be >= 1, and WIDTH must be a multiple of DIGIT. Elaboration error otherwise.
- Derived: NCHUNK = WIDTH/DIGIT.

Ports:
- clk  in  1  single clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request. Accepted only on an edge where ready=1.
- mode  in  1  0 = signed compare (slt), 1 = unsigned compare (sltu).
- x  in  WIDTH  minuend.
- y  in  WIDTH  subtrahend.
- ready  out  1  high only in IDLE.
- done  out  1  one-cycle pulse when results become valid.
- set  out  1  1 when x < y under the latched mode.
- overflow  out  1  signed overflow of x - y. Reported in both modes.
- zero  out  1  1 when x == y.
- diff  out  WIDTH  x - y, modulo 2^WIDTH.

Behaviour:
- Reset, on any edge with reset=1 and overriding everything:
  - state = IDLE, chunk count = 0, carry = 0.
  - set, overflow, zero, diff, done all = 0; ready = 1.
  - Reset mid-RUN or in DONE abandons the operation; no done pulse is produced for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - An edge with start=1 accepts: latch x, y, mode; count = 0; carry = 1 (the +1 of two's complement); go to RUN.
  - set, overflow, zero and diff keep their previous values until the new done.
- RUN:
  - Each edge adds chunk k = count: diff[k*DIGIT +: DIGIT] = x_chunk + ~y_chunk + carry.
  - carry <= carry-out of the chunk; count++.
  - On the final chunk (count = NCHUNK-1), also capture the carry into the MSB (c_msb) and the carry-out (c_out), then go to DONE.
  - Within a chunk the carry ripples bit-by-bit combinationally.
- DONE (exactly one cycle):
  - done = 1.
  - V = c_msb XOR c_out.
  - set = mode ? ~c_out : (diff[WIDTH-1] XOR V).
  - overflow = V.
  - zero = (diff == 0).
  - The next edge returns to IDLE.
- Registered flags (set, overflow, zero, diff) are written on the edge entering DONE and held until the next DONE or reset.
- Latency: accept edge E; done is high during the cycle after edge E+NCHUNK. Initiation interval is NCHUNK+2 cycles.
- start while ready=0 (RUN or DONE) is ignored; it is not queued.
- x, y, mode may change freely after the accept edge; only latched copies are used.
- DIGIT = WIDTH: single RUN cycle (NCHUNK = 1); c_msb comes from within that chunk.
- DIGIT = 1: NCHUNK = WIDTH cycles.
- ready = (state == IDLE); it is combinational from state only.

Test Plan:
- WIDTH=32, DIGIT=4, mode=0, x=1, y=7, start pulsed in IDLE:
  - done high exactly 8 edges after accept;
  - diff=0xFFFFFFFA, set=1, overflow=0, zero=0.
- x=0xFFFFFFFF, y=0x00000001:
  - mode=0 → set=1, diff=0xFFFFFFFE, overflow=0;
  - repeat with mode=1 → set=0, same diff.
- x=0x80000000, y=1, mode=0:
  - diff=0x7FFFFFFF, overflow=1, set=1.
- x=0x7FFFFFFF, y=0xFFFFFFFF, mode=0:
  - diff=0x80000000, overflow=1, set=0.
- x=y=0x12345678:
  - zero=1, set=0, diff=0, in both modes.
- Handshake/reset:
  - start with new operands held high through RUN → ignored; the first result is unchanged and ready returns 1 after DONE.
  - reset asserted on the 3rd RUN edge → no done pulse, all outputs 0, ready=1.
  - A following accept then completes normally.
  - Repeat at DIGIT=1 (done after 32 edges) and DIGIT=32 (done after 1 edge) with identical results.

Source files
------------

// File: rtl/slt_seq.sv
// Multi-cycle set-less-than unit: computes x - y as x + ~y + 1, DIGIT bits per
// clock (LSB chunk first), and reports set, signed overflow, zero and the difference.
module slt_seq #(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             ready,
    output logic             done,
    output logic             set,
    output logic             overflow,
    output logic             zero,
    output logic [WIDTH-1:0] diff
);

    localparam int NCHUNK = (DIGIT >= 1) ? (WIDTH / DIGIT) : 1;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : gBadParams
        $error("slt_seq: WIDTH must be >= 2 and a multiple of DIGIT >= 1");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    count_q;
    logic             carry_q;
    logic             mode_q;
    logic [WIDTH-1:0] xOp_q;
    logic [WIDTH-1:0] yOp_q;
    logic [WIDTH-1:0] work_q;
    logic [WIDTH-1:0] diff_q;
    logic             set_q;
    logic             overflow_q;
    logic             zero_q;
    logic             done_q;

    logic [DIGIT-1:0] xChunk;
    logic [DIGIT-1:0] yChunk;
    logic             ripple;
    logic             cMsb;
    logic             carry_d;
    logic [WIDTH-1:0] diff_d;
    logic             overflow_d;
    logic             set_d;
    logic             lastChunk;

    // One chunk of the subtraction; on the last chunk cMsb is the carry into bit WIDTH-1.
    always_comb begin
        xChunk = '0;
        yChunk = '0;
        diff_d = work_q;
        for (int k = 0; k < NCHUNK; k++) begin
            if (count_q == CW'(k)) begin
                xChunk = xOp_q[k*DIGIT +: DIGIT];
                yChunk = yOp_q[k*DIGIT +: DIGIT];
            end
        end
        ripple = carry_q;
        cMsb   = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            if (i == DIGIT - 1) begin
                cMsb = ripple;
            end
            for (int k = 0; k < NCHUNK; k++) begin
                if (count_q == CW'(k)) begin
                    diff_d[k*DIGIT + i] = xChunk[i] ^ ~yChunk[i] ^ ripple;
                end
            end
            ripple = (xChunk[i] & ~yChunk[i]) | (ripple & (xChunk[i] ^ ~yChunk[i]));
        end
        carry_d    = ripple;
        overflow_d = cMsb ^ carry_d;
        set_d      = mode_q ? ~carry_d : (diff_d[WIDTH-1] ^ overflow_d);
        lastChunk  = (count_q == CW'(NCHUNK - 1));
    end

    // Control FSM; result flags only change on the edge that enters DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            count_q    <= '0;
            carry_q    <= 1'b0;
            mode_q     <= 1'b0;
            xOp_q      <= '0;
            yOp_q      <= '0;
            work_q     <= '0;
            diff_q     <= '0;
            set_q      <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        xOp_q   <= x;
                        yOp_q   <= y;
                        mode_q  <= mode;
                        count_q <= '0;
                        carry_q <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    work_q  <= diff_d;
                    carry_q <= carry_d;
                    count_q <= count_q + CW'(1);
                    if (lastChunk) begin
                        diff_q     <= diff_d;
                        set_q      <= set_d;
                        overflow_q <= overflow_d;
                        zero_q     <= (diff_d == '0);
                        done_q     <= 1'b1;
                        state_q    <= DONE;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready    = (state_q == IDLE);
    assign done     = done_q;
    assign set      = set_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;
    assign diff     = diff_q;

endmodule

// File: tb/tb_slt_seq.sv
// Directed bench for slt_seq at DIGIT=4, DIGIT=1 and DIGIT=32 side by side,
// sharing operands and reset but with a separate start per instance.
module tb_slt_seq;

    logic        clk;
    logic        reset;
    logic [2:0]  startV;
    logic        modeIn;
    logic [31:0] xIn;
    logic [31:0] yIn;
    logic [2:0]  readyV;
    logic [2:0]  doneV;
    logic [2:0]  setV;
    logic [2:0]  ovfV;
    logic [2:0]  zeroV;
    logic [31:0] diffV [3];

    int total;
    int bad;
    int lat [3];
    int pulses [3];
    int nchunk [3] = '{8, 32, 1};

    slt_seq #(.WIDTH(32), .DIGIT(4)) dut4 (
        .clk(clk), .reset(reset), .start(startV[0]), .mode(modeIn), .x(xIn), .y(yIn),
        .ready(readyV[0]), .done(doneV[0]), .set(setV[0]), .overflow(ovfV[0]),
        .zero(zeroV[0]), .diff(diffV[0])
    );

    slt_seq #(.WIDTH(32), .DIGIT(1)) dut1 (
        .clk(clk), .reset(reset), .start(startV[1]), .mode(modeIn), .x(xIn), .y(yIn),
        .ready(readyV[1]), .done(doneV[1]), .set(setV[1]), .overflow(ovfV[1]),
        .zero(zeroV[1]), .diff(diffV[1])
    );

    slt_seq #(.WIDTH(32), .DIGIT(32)) dut32 (
        .clk(clk), .reset(reset), .start(startV[2]), .mode(modeIn), .x(xIn), .y(yIn),
        .ready(readyV[2]), .done(doneV[2]), .set(setV[2]), .overflow(ovfV[2]),
        .zero(zeroV[2]), .diff(diffV[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Starts all three instances, scrambles the inputs after accept, and records
    // each instance's done latency (edges after accept) and pulse count.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic m);
        xIn    = a;
        yIn    = b;
        modeIn = m;
        startV = 3'b111;
        @(posedge clk);
        #1;
        startV = 3'b000;
        xIn    = ~a;
        yIn    = a ^ b;
        modeIn = ~m;
        for (int i = 0; i < 3; i++) begin
            lat[i]    = 0;
            pulses[i] = 0;
        end
        for (int k = 1; k <= 36; k++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (doneV[i]) begin
                    pulses[i]++;
                    if (lat[i] == 0) lat[i] = k;
                end
            end
        end
    endtask

    task automatic test_reset;
        reset  = 1'b1;
        startV = 3'b000;
        xIn    = 32'hDEADBEEF;
        yIn    = 32'h0;
        modeIn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({readyV[i], doneV[i], setV[i], ovfV[i], zeroV[i], diffV[i]} !== {5'b10000, 32'h0}) begin
                bad++;
                $display("[TB] FAIL reset_state dut%0d: got rdy=%b done=%b set=%b ovf=%b zero=%b diff=%h want 1 0 0 0 0 00000000",
                         i, readyV[i], doneV[i], setV[i], ovfV[i], zeroV[i], diffV[i]);
            end
        end
    endtask

    task automatic test_compare(input string name, input logic [31:0] a, input logic [31:0] b,
                                input logic m, input logic [31:0] expDiff, input logic expSet,
                                input logic expOvf, input logic expZero);
        applyStimulus(a, b, m);
        for (int i = 0; i < 3; i++) begin
            total++;
            if (lat[i] !== nchunk[i]) begin
                bad++;
                $display("[TB] FAIL %s_latency dut%0d: got %0d want %0d", name, i, lat[i], nchunk[i]);
            end
            total++;
            if (pulses[i] !== 1) begin
                bad++;
                $display("[TB] FAIL %s_pulses dut%0d: got %0d want 1", name, i, pulses[i]);
            end
            total++;
            if ({setV[i], ovfV[i], zeroV[i], diffV[i]} !== {expSet, expOvf, expZero, expDiff}) begin
                bad++;
                $display("[TB] FAIL %s_result dut%0d: got set=%b ovf=%b zero=%b diff=%h want %b %b %b %h",
                         name, i, setV[i], ovfV[i], zeroV[i], diffV[i], expSet, expOvf, expZero, expDiff);
            end
        end
    endtask

    // DIGIT=4 instance only: start stays high with new operands through RUN.
    task automatic test_ignore_start;
        int extra;
        xIn    = 32'd1;
        yIn    = 32'd7;
        modeIn = 1'b0;
        startV = 3'b001;
        @(posedge clk);
        #1;
        xIn = 32'd5;
        yIn = 32'd2;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            total++;
            if (k < 8 && {readyV[0], doneV[0]} !== 2'b00) begin
                bad++;
                $display("[TB] FAIL ignore_run_flags edge%0d: got rdy=%b done=%b want 0 0", k, readyV[0], doneV[0]);
            end else if (k == 8 && {readyV[0], doneV[0], diffV[0]} !== {2'b01, 32'hFFFFFFFA}) begin
                bad++;
                $display("[TB] FAIL ignore_done: got rdy=%b done=%b diff=%h want 0 1 fffffffa", readyV[0], doneV[0], diffV[0]);
            end
        end
        startV = 3'b000;
        @(posedge clk);
        #1;
        total++;
        if ({readyV[0], setV[0], diffV[0]} !== {2'b11, 32'hFFFFFFFA}) begin
            bad++;
            $display("[TB] FAIL ignore_after: got rdy=%b set=%b diff=%h want 1 1 fffffffa", readyV[0], setV[0], diffV[0]);
        end
        extra = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk);
            #1;
            if (doneV[0] || !readyV[0]) extra++;
        end
        total++;
        if (extra !== 0) begin
            bad++;
            $display("[TB] FAIL ignore_not_queued: got %0d busy cycles want 0", extra);
        end
    endtask

    task automatic test_reset_midrun;
        int lateDone;
        xIn    = 32'd9;
        yIn    = 32'd4;
        modeIn = 1'b0;
        startV = 3'b111;
        @(posedge clk);
        #1;
        startV = 3'b000;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            total++;
            if ({readyV[i], doneV[i], setV[i], ovfV[i], zeroV[i], diffV[i]} !== {5'b10000, 32'h0}) begin
                bad++;
                $display("[TB] FAIL midrun_reset dut%0d: got rdy=%b done=%b set=%b ovf=%b zero=%b diff=%h want 1 0 0 0 0 00000000",
                         i, readyV[i], doneV[i], setV[i], ovfV[i], zeroV[i], diffV[i]);
            end
        end
        lateDone = 0;
        for (int k = 0; k < 36; k++) begin
            @(posedge clk);
            #1;
            if (doneV[0] || doneV[1]) lateDone++;
        end
        total++;
        if (lateDone !== 0) begin
            bad++;
            $display("[TB] FAIL midrun_no_done: got %0d done cycles want 0", lateDone);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_compare("basic",      32'd1,        32'd7,        1'b0, 32'hFFFFFFFA, 1'b1, 1'b0, 1'b0);
        test_compare("neg1_slt",   32'hFFFFFFFF, 32'h00000001, 1'b0, 32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
        test_compare("neg1_sltu",  32'hFFFFFFFF, 32'h00000001, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
        test_compare("ovf_min",    32'h80000000, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0);
        test_compare("ovf_min_u",  32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
        test_compare("ovf_max",    32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0);
        test_compare("equal_slt",  32'h12345678, 32'h12345678, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1);
        test_compare("equal_sltu", 32'h12345678, 32'h12345678, 1'b1, 32'h00000000, 1'b0, 1'b0, 1'b1);
        test_ignore_start();
        test_reset_midrun();
        test_compare("post_reset", 32'h00000002, 32'h80000000, 1'b1, 32'h80000002, 1'b1, 1'b1, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
